// File: rtl/lidar_dec_pkg.sv
// Shared types and constants for the LiDAR decode path.
// Includes the saturating min helper used by the payload serializer.
package lidar_dec_pkg;

    localparam int unsigned LIDAR_FRAME_W = 512;
    localparam int unsigned LIDAR_SIZE_W  = 10;
    localparam int unsigned LIDAR_META_W  = 128;

    typedef enum logic [0:0] {
        SER_IDLE,
        SER_EMIT
    } ser_state_t;

    function automatic int unsigned sat_min(input int unsigned a, input int unsigned limit);
        return (a > limit) ? limit : a;
    endfunction

endpackage

// File: rtl/lidar_payload_serializer.sv
// Serializes one LSB-aligned sliced payload into OUT_W-bit words with last/nbits marking.
// Define LIDAR_SER_STATS_EN to add stat_frames / stat_stall counters.
module lidar_payload_serializer
    import lidar_dec_pkg::*;
#(
    parameter int unsigned FRAME_W = LIDAR_FRAME_W,
    parameter int unsigned SIZE_W  = LIDAR_SIZE_W,
    parameter int unsigned OUT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FRAME_W-1:0]         in_data,
    input  logic [SIZE_W-1:0]          in_size,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(OUT_W):0]     out_nbits,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready
`ifdef LIDAR_SER_STATS_EN
    ,
    output logic [15:0]                stat_frames,
    output logic [15:0]                stat_stall
`endif
);

    localparam int unsigned NB_W  = $clog2(OUT_W) + 1;
    localparam int unsigned REM_W = SIZE_W + 1;

    ser_state_t         state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [REM_W-1:0]   rem_q, rem_d, rem_ld;
    logic [OUT_W-1:0]   data_q, data_d;
    logic [NB_W-1:0]    nbits_q, nbits_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;

    assign in_ready  = (state_q == SER_IDLE);
    assign out_data  = data_q;
    assign out_nbits = nbits_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

    assign rem_ld = REM_W'(sat_min(32'(in_size), FRAME_W));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        rem_d   = rem_q;
        unique case (state_q)
            SER_IDLE: begin
                if (in_valid && (rem_ld != '0)) begin
                    shreg_d = in_data;
                    rem_d   = rem_ld;
                    state_d = SER_EMIT;
                end
            end
            SER_EMIT: begin
                if (out_ready) begin
                    shreg_d = shreg_q >> OUT_W;
                    // Last word clears rem instead of subtracting, so rem never wraps.
                    if (rem_q <= REM_W'(OUT_W)) begin
                        rem_d   = '0;
                        state_d = SER_IDLE;
                    end else begin
                        rem_d = rem_q - REM_W'(OUT_W);
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase

        // Output registers are loaded from next-state so they line up with state_q.
        valid_d = (state_d == SER_EMIT);
        nbits_d = valid_d ? NB_W'(sat_min(32'(rem_d), OUT_W)) : '0;
        last_d  = valid_d && (rem_d <= REM_W'(OUT_W));
        for (int i = 0; i < int'(OUT_W); i++) begin
            data_d[i] = shreg_d[i] && (NB_W'(i) < nbits_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_IDLE;
            shreg_q <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            nbits_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            nbits_q <= nbits_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

`ifdef LIDAR_SER_STATS_EN
    logic [15:0] frames_q, stall_q;

    assign stat_frames = frames_q;
    assign stat_stall  = stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= '0;
            stall_q  <= '0;
        end else begin
            if (valid_q && out_ready && last_q) begin
                frames_q <= frames_q + 16'd1;
            end
            if (valid_q && !out_ready) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lidar_payload_serializer.sv
// Self-checking bench: beat-queue model checked every cycle plus directed literal checks.
// Stats checks are compiled in when LIDAR_SER_STATS_EN is defined.
module tb_lidar_payload_serializer;

    localparam int unsigned FRAME_W = 512;
    localparam int unsigned SIZE_W  = 10;
    localparam int unsigned OUT_W   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [FRAME_W-1:0] in_data;
    logic [SIZE_W-1:0]  in_size;
    logic               in_valid;
    logic               in_ready;
    logic [OUT_W-1:0]   out_data;
    logic [5:0]         out_nbits;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;
`ifdef LIDAR_SER_STATS_EN
    logic [15:0]        stat_frames;
    logic [15:0]        stat_stall;
`endif

    lidar_payload_serializer #(
        .FRAME_W(FRAME_W),
        .SIZE_W (SIZE_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_size  (in_size),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_nbits(out_nbits),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef LIDAR_SER_STATS_EN
        ,
        .stat_frames(stat_frames),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          nbits;
        bit          last;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;
    int    model_beats = 0;
    int    pay_beats = 0;
    int    tot_beats = 0;
    int    seen_last_nbits = 0;
    logic [31:0] seen_first_data = '0;
    logic [31:0] seen_last_data = '0;
    int    frames_m = 0;
    int    stall_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Split a payload into expected words straight from the length rules.
    function automatic void model_push(input logic [FRAME_W-1:0] d, input int size);
        int n;
        int k;
        n = (size > int'(FRAME_W)) ? int'(FRAME_W) : size;
        k = 0;
        while (32 * k < n) begin
            beat_t b;
            logic [31:0] w;
            w = d[32*k +: 32];
            b.nbits = (n - 32 * k > 32) ? 32 : n - 32 * k;
            for (int i = 0; i < 32; i++) begin
                if (i >= b.nbits) w[i] = 1'b0;
            end
            b.data = w;
            b.last = (32 * (k + 1) >= n);
            q.push_back(b);
            k++;
        end
        model_beats = k;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            bit busy;
            busy = (q.size() != 0);
            chk("in_ready", 64'(in_ready), 64'(!busy));
            chk("out_valid", 64'(out_valid), 64'(busy));
            if (busy) begin
                chk("out_data", 64'(out_data), 64'(q[0].data));
                chk("out_nbits", 64'(out_nbits), 64'(q[0].nbits));
                chk("out_last", 64'(out_last), 64'(q[0].last));
            end else begin
                chk("idle_data", 64'(out_data), 64'd0);
                chk("idle_nbits", 64'(out_nbits), 64'd0);
                chk("idle_last", 64'(out_last), 64'd0);
            end
`ifdef LIDAR_SER_STATS_EN
            chk("stat_frames", 64'(stat_frames), 64'(frames_m[15:0]));
            chk("stat_stall", 64'(stat_stall), 64'(stall_m[15:0]));
`endif
            if (rst) begin
                q.delete();
                frames_m = 0;
                stall_m = 0;
            end else if (busy) begin
                if (out_ready) begin
                    if (pay_beats == 0) seen_first_data = out_data;
                    pay_beats++;
                    tot_beats++;
                    seen_last_nbits = int'(out_nbits);
                    seen_last_data = out_data;
                    if (q[0].last) frames_m++;
                    void'(q.pop_front());
                end else begin
                    stall_m++;
                end
            end else if (in_valid) begin
                pay_beats = 0;
                model_push(in_data, int'(in_size));
            end
        end
    end

    task automatic send(input int size, input logic [FRAME_W-1:0] d);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_size = SIZE_W'(size);
        in_data = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("wait_idle_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (pay_beats < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (pay_beats < target) chk("wait_beats_timeout", 64'(pay_beats), 64'(target));
    endtask

    logic [FRAME_W-1:0] inc_bytes;
    logic [FRAME_W-1:0] pat_a5;

    initial begin
        int tot_save;
`ifdef LIDAR_SER_STATS_EN
        int stall_save;
        int frames_save;
`endif
        for (int i = 0; i < 64; i++) inc_bytes[8*i +: 8] = 8'(i);
        for (int i = 0; i < 64; i++) pat_a5[8*i +: 8] = 8'hA5 ^ 8'(i);

        rst = 1'b1;
        in_valid = 1'b0;
        in_size = '0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_nbits", 64'(out_nbits), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 383 bits: 12 beats, last carries 31 bits
        send(383, inc_bytes);
        chk("t383_model_beats", 64'(model_beats), 64'd12);
        wait_idle();
        chk("t383_beats", 64'(pay_beats), 64'd12);
        chk("t383_first_data", 64'(seen_first_data), 64'h03020100);
        chk("t383_last_nbits", 64'(seen_last_nbits), 64'd31);
        chk("t383_last_data", 64'(seen_last_data), 64'h2F2E2D2C);

        // Exactly one word
        send(32, pat_a5);
        wait_idle();
        chk("t32_beats", 64'(pay_beats), 64'd1);
        chk("t32_nbits", 64'(seen_last_nbits), 64'd32);
        chk("t32_data", 64'(seen_last_data), 64'hA6A7A4A5);

        // Zero-length payload is dropped
        tot_save = tot_beats;
        send(0, inc_bytes);
        repeat (5) @(negedge clk);
        chk("t0_no_beats", 64'(tot_beats), 64'(tot_save));
        chk("t0_in_ready", 64'(in_ready), 64'd1);
        send(64, inc_bytes);
        wait_idle();
        chk("t64_beats", 64'(pay_beats), 64'd2);
        chk("t64_last_data", 64'(seen_last_data), 64'h07060504);

        // Oversize saturates to the frame width
        send(600, pat_a5);
        chk("t600_model_beats", 64'(model_beats), 64'd16);
        wait_idle();
        chk("t600_beats", 64'(pay_beats), 64'd16);
        chk("t600_last_nbits", 64'(seen_last_nbits), 64'd32);

        // Backpressure on beat 1 for three cycles
`ifdef LIDAR_SER_STATS_EN
        stall_save = int'(stat_stall);
        frames_save = int'(stat_frames);
`endif
        send(100, inc_bytes);
        wait_beats(1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();
        chk("t100_beats", 64'(pay_beats), 64'd4);
        chk("t100_last_nbits", 64'(seen_last_nbits), 64'd4);
        chk("t100_last_data", 64'(seen_last_data), 64'h0000000C);
`ifdef LIDAR_SER_STATS_EN
        @(negedge clk);
        chk("t100_stall", 64'(int'(stat_stall) - stall_save), 64'd3);
        chk("t100_frames", 64'(int'(stat_frames) - frames_save), 64'd1);
`endif

        // Reset in the middle of a payload
        send(383, inc_bytes);
        wait_beats(5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("trst_out_valid", 64'(out_valid), 64'd0);
        chk("trst_out_last", 64'(out_last), 64'd0);
        chk("trst_in_ready", 64'(in_ready), 64'd1);
        send(8, pat_a5);
        wait_idle();
        chk("t8_beats", 64'(pay_beats), 64'd1);
        chk("t8_nbits", 64'(seen_last_nbits), 64'd8);
        chk("t8_data", 64'(seen_last_data), 64'h000000A5);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
